// File: rtl/loopback_msg_monitor.sv
// Avalon-ST loopback: 2-entry skid buffer with a framing monitor that pulses msg_enter/frame_err.
// Optional MSG_LEN_CHECK_EN macro enables the MAX_LEN_BEATS packet length limit.
module loopback_msg_monitor #(
  parameter int DATA_WIDTH    = 32,
  parameter int LEN_WIDTH     = 16,
  parameter int MAX_LEN_BEATS = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] snk_data,
  input  logic                  snk_valid,
  input  logic                  snk_sop,
  input  logic                  snk_eop,
  output logic                  snk_ready,
  output logic [DATA_WIDTH-1:0] src_data,
  output logic                  src_valid,
  output logic                  src_sop,
  output logic                  src_eop,
  input  logic                  src_ready,
  output logic                  msg_enter,
  output logic                  frame_err,
  output logic [LEN_WIDTH-1:0]  last_len
);

`ifdef MSG_LEN_CHECK_EN
  localparam bit LEN_CHECK = 1'b1;
`else
  localparam bit LEN_CHECK = 1'b0;
`endif

  localparam logic [LEN_WIDTH-1:0] LEN_SAT = '1;
  localparam logic [LEN_WIDTH-1:0] MAX_L   = LEN_WIDTH'(MAX_LEN_BEATS);
  localparam logic [LEN_WIDTH-1:0] MAX_P1  = LEN_WIDTH'(MAX_LEN_BEATS + 1);

  typedef enum logic {IDLE = 1'b0, IN_PKT = 1'b1} state_t;

  function automatic logic [LEN_WIDTH-1:0] sat_inc(input logic [LEN_WIDTH-1:0] v);
    return (v == LEN_SAT) ? v : v + 1'b1;
  endfunction

  logic                  out_valid_q, out_valid_d, out_sop_q, out_sop_d, out_eop_q, out_eop_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  skid_valid_q, skid_valid_d, skid_sop_q, skid_sop_d, skid_eop_q, skid_eop_d;
  logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
  logic                  snk_ready_q, snk_ready_d;
  logic                  accept;

  state_t                state_q, state_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d, last_len_q, last_len_d, beat_cnt;
  logic                  msg_enter_q, msg_enter_d, frame_err_q, frame_err_d;
  logic                  counted;

  assign accept = snk_valid & snk_ready_q;

  // Skid buffer: the output entry refills from the skid entry first so order is preserved.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_sop_d    = out_sop_q;
    out_eop_d    = out_eop_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_sop_d   = skid_sop_q;
    skid_eop_d   = skid_eop_q;
    skid_data_d  = skid_data_q;
    if (!out_valid_q || src_ready) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_sop_d    = skid_sop_q;
        out_eop_d    = skid_eop_q;
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = accept;
        if (accept) begin
          out_sop_d  = snk_sop;
          out_eop_d  = snk_eop;
          out_data_d = snk_data;
        end
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_sop_d   = snk_sop;
      skid_eop_d   = snk_eop;
      skid_data_d  = snk_data;
    end
    snk_ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_sop_q    <= 1'b0;
      out_eop_q    <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_sop_q   <= 1'b0;
      skid_eop_q   <= 1'b0;
      skid_data_q  <= '0;
      snk_ready_q  <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_sop_q    <= out_sop_d;
      out_eop_q    <= out_eop_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_sop_q   <= skid_sop_d;
      skid_eop_q   <= skid_eop_d;
      skid_data_q  <= skid_data_d;
      snk_ready_q  <= snk_ready_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      len_q       <= '0;
      last_len_q  <= '0;
      msg_enter_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      last_len_q  <= last_len_d;
      msg_enter_q <= msg_enter_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (accept) begin
      if (snk_sop)
        state_d = snk_eop ? IDLE : IN_PKT;
      else if (state_q == IN_PKT && snk_eop)
        state_d = IDLE;
    end
  end

  // A SOP always restarts the count, abandoning any packet in flight.
  always_comb begin
    beat_cnt    = snk_sop ? LEN_WIDTH'(1) : sat_inc(len_q);
    counted     = snk_sop || (state_q == IN_PKT);
    len_d       = len_q;
    last_len_d  = last_len_q;
    msg_enter_d = 1'b0;
    frame_err_d = 1'b0;
    if (accept) begin
      frame_err_d = snk_sop ? (state_q == IN_PKT) : (state_q == IDLE);
      if (counted) begin
        len_d = beat_cnt;
        if (LEN_CHECK && beat_cnt == MAX_P1)
          frame_err_d = 1'b1;
        if (snk_eop) begin
          len_d = '0;
          if (!(LEN_CHECK && beat_cnt > MAX_L)) begin
            msg_enter_d = 1'b1;
            last_len_d  = beat_cnt;
          end
        end
      end
    end
  end

  assign snk_ready = snk_ready_q;
  assign src_valid = out_valid_q;
  assign src_sop   = out_sop_q;
  assign src_eop   = out_eop_q;
  assign src_data  = out_data_q;
  assign msg_enter = msg_enter_q;
  assign frame_err = frame_err_q;
  assign last_len  = last_len_q;

endmodule
